// File: rtl/serial_adder_sequencer.sv
`default_nettype none
// ============================================================================
// Module : serial_adder_sequencer
// Brief  : Bit-serial add/subtract controller driving one shared 1-bit adder.
// Rev    : 1.0
// ============================================================================
module serial_adder_sequencer #(
   parameter int WIDTH     = 8,
   parameter int ADDER_LAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             busy,
   output logic             add_a,
   output logic             add_b,
   output logic             add_cin,
   input  logic             add_sum,
   input  logic             add_cout
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int CNT_W = (ADDER_LAT > 0) ? $clog2(ADDER_LAT + 1) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ADDER_LAT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [IDX_W-1:0] bit_idx_q;
   logic [IDX_W-1:0] bit_idx_d;
   logic [CNT_W-1:0] wait_cnt_q;
   logic [WIDTH-1:0] op_a_q;
   logic [WIDTH-1:0] op_b_q;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] result_d;
   logic [WIDTH-1:0] out_sum_q;
   logic [WIDTH-1:0] a_sh_d;
   logic [WIDTH-1:0] b_sh_d;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             out_cout_q;
   logic             busy_q;
   logic             add_a_q;
   logic             add_b_q;
   logic             add_cin_q;
   logic             step_done;
   logic             last_bit;

   always_comb begin
      bit_idx_d           = bit_idx_q + 1'b1;
      result_d            = result_q;
      result_d[bit_idx_q] = add_sum;
      a_sh_d              = op_a_q >> bit_idx_d;
      b_sh_d              = op_b_q >> bit_idx_d;
   end

   assign step_done = (wait_cnt_q == LAST_CNT);
   assign last_bit  = (bit_idx_q == LAST_IDX);

   // add_cin_q doubles as the running carry register between bit steps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         bit_idx_q   <= '0;
         wait_cnt_q  <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         result_q    <= '0;
         out_sum_q   <= '0;
         out_cout_q  <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         add_a_q     <= 1'b0;
         add_b_q     <= 1'b0;
         add_cin_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid && in_ready_q) begin
                  op_a_q     <= in_a;
                  op_b_q     <= in_sub ? ~in_b : in_b;
                  add_a_q    <= in_a[0];
                  add_b_q    <= in_b[0] ^ in_sub;
                  add_cin_q  <= in_sub | in_cin;
                  bit_idx_q  <= '0;
                  wait_cnt_q <= '0;
                  result_q   <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= S_RUN;
               end
            end
            S_RUN: begin
               if (step_done) begin
                  result_q   <= result_d;
                  wait_cnt_q <= '0;
                  if (last_bit) begin
                     out_sum_q   <= result_d;
                     out_cout_q  <= add_cout;
                     out_valid_q <= 1'b1;
                     add_a_q     <= 1'b0;
                     add_b_q     <= 1'b0;
                     add_cin_q   <= 1'b0;
                     state_q     <= S_DONE;
                  end else begin
                     bit_idx_q <= bit_idx_d;
                     add_a_q   <= a_sh_d[0];
                     add_b_q   <= b_sh_d[0];
                     add_cin_q <= add_cout;
                  end
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_cout  = out_cout_q;
   assign busy      = busy_q;
   assign add_a     = add_a_q;
   assign add_b     = add_b_q;
   assign add_cin   = add_cin_q;

endmodule
`default_nettype wire
